// File: rtl/arith_pkg.sv
// Shared definitions for the arithmetic library (Inc/Dec/Add blocks).
// Contents:
//   speed_e   - architecture selector for the carry/prefix network
//   WIDTH_MIN - smallest legal operand width
//   SPEED_MAX - largest legal speed code
//   speed_ok  - legality test for a speed code
package arith_pkg;

  typedef enum logic [1:0] {
    SPEED_SLOW   = 2'd0,
    SPEED_MEDIUM = 2'd1,
    SPEED_FAST   = 2'd2
  } speed_e;

  localparam int WIDTH_MIN = 2;
  localparam int SPEED_MAX = 2;

  function automatic bit speed_ok(input int s);
    return (s >= 0) && (s <= SPEED_MAX);
  endfunction

endpackage

// File: rtl/inc_counter_inc.sv
// Inc: combinational incrementer, Z = A + 1 modulo 2^width.
// Bit i of the sum flips when all lower bits of A are one, so the block
// is a prefix-AND network over A followed by an XOR row. The carry-out is
// not produced.
// Parameters:
//   width - operand width (>= 2)
//   speed - 0 serial chain, 1 Brent-Kung, 2 Sklansky
// Ports:
//   A - operand (in,  width)
//   Z - A + 1   (out, width)
module Inc
  import arith_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = int'(SPEED_MEDIUM)
) (
  input  logic [width-1:0] A,
  output logic [width-1:0] Z
);

  // Only A[width-2:0] feeds the prefix network: the top bit's prefix would
  // be the carry-out, which nothing needs.
  localparam int N  = width - 1;
  localparam int LG = (N > 1) ? $clog2(N) : 1;

  // pre[i] = &A[i:0]
  logic [N-1:0] pre;

  generate
    if (width < WIDTH_MIN) begin : g_chk_width
      $error("Inc: width must be >= 2");
    end
    if (!speed_ok(speed)) begin : g_chk_speed
      $error("Inc: speed must be 0, 1 or 2");
    end

    if (speed == int'(SPEED_SLOW)) begin : g_serial
      always_comb begin
        logic [N-1:0] acc;
        acc    = '0;
        acc[0] = A[0];
        for (int i = 1; i < N; i++) begin
          acc[i] = acc[i-1] & A[i];
        end
        pre = acc;
      end
    end else if (speed == int'(SPEED_FAST)) begin : g_sklansky
      logic [N-1:0] st [0:LG];
      assign st[0] = A[N-1:0];
      for (genvar s = 0; s < LG; s++) begin : g_lvl
        for (genvar i = 0; i < N; i++) begin : g_bit
          // Upper half of each 2^(s+1) block takes the last bit of the lower half.
          if (((i >> s) & 1) == 1) begin : g_op
            assign st[s+1][i] = st[s][i] & st[s][((i >> s) << s) - 1];
          end else begin : g_pass
            assign st[s+1][i] = st[s][i];
          end
        end
      end
      assign pre = st[LG];
    end else begin : g_brent_kung
      logic [N-1:0] st [0:2*LG-1];
      assign st[0] = A[N-1:0];
      // Up-sweep: combine aligned blocks of doubling size.
      for (genvar s = 0; s < LG; s++) begin : g_up
        for (genvar i = 0; i < N; i++) begin : g_bit
          if (((i + 1) % (2 << s)) == 0) begin : g_op
            assign st[s+1][i] = st[s][i] & st[s][i - (1 << s)];
          end else begin : g_pass
            assign st[s+1][i] = st[s][i];
          end
        end
      end
      // Down-sweep: fill in the odd-multiple positions from completed prefixes.
      for (genvar d = 0; d < LG - 1; d++) begin : g_down
        localparam int L = LG - 2 - d;
        for (genvar i = 0; i < N; i++) begin : g_bit
          if ((((i + 1) % (2 << L)) == (1 << L)) && ((i + 1) > (2 << L))) begin : g_op
            assign st[LG+d+1][i] = st[LG+d][i] & st[LG+d][i - (1 << L)];
          end else begin : g_pass
            assign st[LG+d+1][i] = st[LG+d][i];
          end
        end
      end
      assign pre = st[2*LG-1];
    end
  endgenerate

  assign Z = A ^ {pre, 1'b1};

endmodule

// File: rtl/inc_counter.sv
// inc_counter: registered modulo up-counter, sequence 0..MAX, built around Inc.
// Parameters:
//   width - counter width (>= 2)
//   speed - Inc architecture (0 serial, 1 Brent-Kung, 2 Sklansky)
// Ports:
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-high reset
//   CLR  in  synchronous clear of Q/TC/WRAP/OVF (highest priority)
//   LD   in  synchronous load of D into Q
//   D    in  load value (may exceed MAX)
//   EN   in  count enable
//   MAX  in  terminal count
//   Q    out current count
//   TC   out 1 while Q == MAX (registered)
//   WRAP out one-cycle pulse after a wrap to 0
//   OVF  out sticky wrap flag
module inc_counter
  import arith_pkg::*;
#(
  parameter int width = 8,
  parameter int speed = int'(SPEED_MEDIUM)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             LD,
  input  logic [width-1:0] D,
  input  logic             EN,
  input  logic [width-1:0] MAX,
  output logic [width-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             OVF
);

  generate
    if (width < WIDTH_MIN) begin : g_chk_width
      $error("inc_counter: width must be >= 2");
    end
    if (!speed_ok(speed)) begin : g_chk_speed
      $error("inc_counter: speed must be 0, 1 or 2");
    end
  endgenerate

  logic [width-1:0] q_r;
  logic [width-1:0] q_inc;
  logic             tc_r;
  logic             wrap_r;
  logic             ovf_r;
  logic             max_zero;
  logic             wrap_cond;

  Inc #(.width(width), .speed(speed)) u_inc (
    .A (q_r),
    .Z (q_inc)
  );

  assign max_zero  = (MAX == '0);
  // All-ones also wraps so that a load above MAX still returns to 0.
  assign wrap_cond = (q_r == MAX) || (&q_r);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q_r    <= '0;
      tc_r   <= 1'b0;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (CLR) begin
      q_r    <= '0;
      tc_r   <= max_zero;
      wrap_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else if (LD) begin
      q_r    <= D;
      tc_r   <= (D == MAX);
      wrap_r <= 1'b0;
    end else if (EN) begin
      if (wrap_cond) begin
        q_r    <= '0;
        tc_r   <= max_zero;
        wrap_r <= 1'b1;
        ovf_r  <= 1'b1;
      end else begin
        q_r    <= q_inc;
        tc_r   <= (q_inc == MAX);
        wrap_r <= 1'b0;
      end
    end else begin
      tc_r   <= (q_r == MAX);
      wrap_r <= 1'b0;
    end
  end

  // The TC register cannot be reset to a MAX-dependent value, so during
  // reset TC is taken straight from the comparator.
  assign TC   = RST ? max_zero : tc_r;
  assign Q    = q_r;
  assign WRAP = wrap_r;
  assign OVF  = ovf_r;

endmodule
